// File: rtl/canny_tile_seq.sv
// Tile sequencer for the Canny edge core: clears the core, streams one 20x20 tile
// in as 80 five-lane beats, collects the 18x18 serial edge bitmap, repeats per tile.

module canny_tile_lane #(
  parameter int PIX_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [PIX_W-1:0] d,
  output logic [PIX_W-1:0] q
);
  always_ff @(posedge clk) begin
    if (reset)     q <= '0;
    else if (load) q <= d;
  end
endmodule

module canny_tile_seq #(
  parameter int PIX_W      = 5,
  parameter int LANES      = 5,
  parameter int LOAD_BEATS = 80,
  parameter int OUT_PIX    = 324,
  parameter int CLR_CYCLES = 1,
  parameter int TIMEOUT    = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [7:0]             num_tiles,
  input  logic                   src_valid,
  input  logic [LANES*PIX_W-1:0] src_data,
  output logic                   src_ready,
  output logic [LANES*PIX_W-1:0] core_pixel,
  output logic                   core_en,
  output logic                   core_load_end,
  output logic                   core_clear,
  input  logic                   core_readable,
  input  logic                   core_edge,
  output logic                   edge_valid,
  output logic                   edge_data,
  output logic                   edge_last,
  output logic [7:0]             tile_idx,
  output logic                   busy,
  output logic                   done,
  output logic                   err_unexp,
  output logic                   err_timeout
);
  localparam int BEAT_W = $clog2(LOAD_BEATS);
  localparam int OUT_W  = $clog2(OUT_PIX + 1);
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam int CLR_W  = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_LOAD, S_DRAIN, S_DONE} state_t;

  state_t              state;
  logic [7:0]          tiles_q;
  logic [BEAT_W-1:0]   beat_cnt;
  logic [OUT_W-1:0]    out_cnt;
  logic [IDLE_W-1:0]   idle_cnt;
  logic [CLR_W-1:0]    clr_cnt;
  logic                drain_fin;
  logic                beat_acc;

  logic [LANES-1:0][PIX_W-1:0] src_lanes, pix_q;

  assign src_lanes  = src_data;
  assign core_pixel = pix_q;
  assign beat_acc   = (state == S_LOAD) & src_valid & src_ready;

  // Lane registers only load on an accepted beat, so core_pixel holds across gaps.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    canny_tile_lane #(.PIX_W(PIX_W)) u_lane (
      .clk   (clk),
      .reset (reset),
      .load  (beat_acc),
      .d     (src_lanes[k]),
      .q     (pix_q[k])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      tiles_q       <= '0;
      beat_cnt      <= '0;
      out_cnt       <= '0;
      idle_cnt      <= '0;
      clr_cnt       <= '0;
      drain_fin     <= 1'b0;
      src_ready     <= 1'b0;
      core_en       <= 1'b0;
      core_load_end <= 1'b0;
      core_clear    <= 1'b0;
      edge_valid    <= 1'b0;
      edge_data     <= 1'b0;
      edge_last     <= 1'b0;
      tile_idx      <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err_unexp     <= 1'b0;
      err_timeout   <= 1'b0;
    end else begin
      core_en    <= 1'b0;
      edge_valid <= 1'b0;
      edge_last  <= 1'b0;
      done       <= 1'b0;

      case (state)
        S_IDLE: begin
          busy <= 1'b0;
          if (start) begin
            tiles_q     <= num_tiles;
            err_unexp   <= 1'b0;
            err_timeout <= 1'b0;
            tile_idx    <= '0;
            busy        <= 1'b1;
            if (num_tiles == 8'd0) begin
              state <= S_DONE;
            end else begin
              state      <= S_CLEAR;
              core_clear <= 1'b1;
              clr_cnt    <= '0;
              beat_cnt   <= '0;
              out_cnt    <= '0;
              idle_cnt   <= '0;
              drain_fin  <= 1'b0;
            end
          end
        end

        S_CLEAR: begin
          if (clr_cnt == CLR_W'(CLR_CYCLES - 1)) begin
            core_clear <= 1'b0;
            src_ready  <= 1'b1;
            state      <= S_LOAD;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end

        S_LOAD: begin
          if (beat_acc) begin
            core_en  <= 1'b1;
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == BEAT_W'(LOAD_BEATS - 1)) begin
              core_load_end <= 1'b1;
              src_ready     <= 1'b0;
              state         <= S_DRAIN;
            end
          end
        end

        S_DRAIN: begin
          // One settle cycle after the final bit so CLEAR begins after edge_last is seen.
          if (drain_fin) begin
            drain_fin <= 1'b0;
            if (tile_idx + 8'd1 == tiles_q) begin
              state <= S_DONE;
            end else begin
              tile_idx   <= tile_idx + 8'd1;
              state      <= S_CLEAR;
              core_clear <= 1'b1;
              clr_cnt    <= '0;
              beat_cnt   <= '0;
              out_cnt    <= '0;
              idle_cnt   <= '0;
            end
          end else if (core_readable) begin
            edge_valid <= 1'b1;
            edge_data  <= core_edge;
            out_cnt    <= out_cnt + 1'b1;
            idle_cnt   <= '0;
            if (out_cnt == OUT_W'(OUT_PIX - 1)) begin
              edge_last     <= 1'b1;
              core_load_end <= 1'b0;
              drain_fin     <= 1'b1;
            end
          end else if (idle_cnt == IDLE_W'(TIMEOUT - 1)) begin
            err_timeout   <= 1'b1;
            core_load_end <= 1'b0;
            state         <= S_DONE;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end

        S_DONE: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase

      // Stray readable outside DRAIN is flagged and dropped; placed last so it
      // wins over the clear performed by a same-cycle start.
      if (core_readable && state != S_DRAIN) err_unexp <= 1'b1;
    end
  end

endmodule

// File: tb/tb_canny_tile_seq.sv
// Directed bench for canny_tile_seq: table of multi-tile runs plus hand-written
// sequences for zero tiles, drain timeout and reset during DRAIN.

module tb_canny_tile_seq;
  localparam int PIX_W = 5;
  localparam int LANES = 5;
  localparam int LOAD_BEATS = 80;
  localparam int OUT_PIX = 324;
  localparam int DW = LANES * PIX_W;

  logic          clk = 1'b0;
  logic          reset, start, src_valid, core_readable, core_edge;
  logic [7:0]    num_tiles;
  logic [DW-1:0] src_data;
  logic          src_ready, core_en, core_load_end, core_clear;
  logic [DW-1:0] core_pixel;
  logic          edge_valid, edge_data, edge_last, busy, done, err_unexp, err_timeout;
  logic [7:0]    tile_idx;

  always #5 clk = ~clk;

  canny_tile_seq dut (
    .clk(clk), .reset(reset), .start(start), .num_tiles(num_tiles),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .core_pixel(core_pixel), .core_en(core_en), .core_load_end(core_load_end),
    .core_clear(core_clear), .core_readable(core_readable), .core_edge(core_edge),
    .edge_valid(edge_valid), .edge_data(edge_data), .edge_last(edge_last),
    .tile_idx(tile_idx), .busy(busy), .done(done),
    .err_unexp(err_unexp), .err_timeout(err_timeout)
  );

  typedef struct {
    int tiles; bit src_gap; bit rd_gap; int inj;
    int exp_en; int exp_edges; int exp_clr; int exp_unexp;
  } vec_t;

  int n_cmp = 0, n_bad = 0;
  logic inj_rd = 1'b0, mon_clr = 1'b0;
  logic [DW-1:0] exp_q[$];

  // monitor counters
  int en_cnt, ev_cnt, ones_cnt, last_cnt, clr_seen, done_cnt, idx_sum;
  int pix_err, hold_err, le_err, last_err, en_tile, tile_bits;
  logic [DW-1:0] last_pix;

  function automatic logic [DW-1:0] pix(int t, int b);
    logic [DW-1:0] r;
    r = '0;
    for (int l = 0; l < LANES; l++) r[l*PIX_W +: PIX_W] = 5'((t*31 + b*5 + l*3) % 32);
    return r;
  endfunction

  function automatic bit ebit(int t, int k);
    return ((k*5 + t*3) % 7) < 3;
  endfunction

  function automatic int exp_ones(int tiles);
    int s = 0;
    for (int t = 0; t < tiles; t++)
      for (int k = 0; k < OUT_PIX; k++) s += int'(ebit(t, k));
    return s;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_clr) begin
      en_cnt = 0; ev_cnt = 0; ones_cnt = 0; last_cnt = 0; clr_seen = 0; done_cnt = 0;
      idx_sum = 0; pix_err = 0; hold_err = 0; le_err = 0; last_err = 0;
      en_tile = 0; tile_bits = 0;
    end else begin
      if (core_clear) begin clr_seen++; en_tile = 0; end
      if (done) done_cnt++;
      if (core_en) begin
        en_cnt++; en_tile++;
        if (core_load_end != (en_tile == LOAD_BEATS)) le_err++;
        if (exp_q.size() == 0) pix_err++;
        else if (exp_q.pop_front() != core_pixel) pix_err++;
      end else if (!reset && core_pixel != last_pix) hold_err++;
      if (edge_valid) begin
        ev_cnt++; tile_bits++;
        ones_cnt += int'(edge_data);
      end
      if (edge_last) begin
        last_cnt++;
        idx_sum += int'(tile_idx);
        if (!edge_valid || tile_bits != OUT_PIX) last_err++;
        tile_bits = 0;
      end
    end
    last_pix = core_pixel;
  end

  task automatic clear_mon();
    @(posedge clk); #1 mon_clr = 1'b1;
    @(posedge clk); #1 mon_clr = 1'b0;
  endtask

  task automatic kick(input logic [7:0] n);
    @(negedge clk); num_tiles = n; start = 1'b1;
    @(negedge clk); start = 1'b0; num_tiles = 8'hAA;
  endtask

  task automatic src_tile(input int t, input bit gap, input int inj_at, output bit ok);
    int b = 0, c = 0;
    while (b < LOAD_BEATS && c < 4000) begin
      @(negedge clk);
      src_valid = gap ? (c % 2 == 0) : 1'b1;
      src_data  = src_valid ? pix(t, b) : ~pix(t, b);
      inj_rd    = (inj_at >= 0) && (b == inj_at || b == inj_at + 1);
      if (src_valid && src_ready) begin exp_q.push_back(src_data); b++; end
      c++;
    end
    @(negedge clk); src_valid = 1'b0; inj_rd = 1'b0;
    ok = (b == LOAD_BEATS);
  endtask

  task automatic core_bits(input int t, input int n, input bit gap, output bit ok);
    int w = 0, k = 0, c = 0;
    while (!core_load_end && w < 5000) begin
      @(negedge clk); core_readable = inj_rd; w++;
    end
    core_readable = 1'b0;
    ok = (w < 5000);
    if (ok) begin
      while (k < n) begin
        if (gap && c % 3 == 2) core_readable = 1'b0;
        else begin core_readable = 1'b1; core_edge = ebit(t, k); k++; end
        c++;
        @(negedge clk);
      end
      core_readable = 1'b0;
    end
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    bit ok_s = 1'b1, ok_c = 1'b1;
    int w = 0;
    clear_mon();
    kick(8'(v.tiles));
    fork
      for (int t = 0; t < v.tiles; t++) begin
        bit ok;
        src_tile(t, v.src_gap, (t == 0) ? v.inj : -1, ok);
        if (!ok) ok_s = 1'b0;
      end
      for (int t = 0; t < v.tiles; t++) begin
        bit ok;
        core_bits(t, OUT_PIX, v.rd_gap, ok);
        if (!ok) ok_c = 1'b0;
      end
    join
    while (done_cnt == 0 && w < 2000) begin @(negedge clk); w++; end
    repeat (3) @(negedge clk);
    chk({tag, " src_complete"}, int'(ok_s), 1);
    chk({tag, " drain_started"}, int'(ok_c), 1);
    chk({tag, " core_en_count"}, en_cnt, v.exp_en);
    chk({tag, " edge_count"}, ev_cnt, v.exp_edges);
    chk({tag, " edge_ones"}, ones_cnt, exp_ones(v.tiles));
    chk({tag, " edge_last_count"}, last_cnt, v.tiles);
    chk({tag, " edge_last_pos"}, last_err, 0);
    chk({tag, " tile_idx_sum"}, idx_sum, v.tiles * (v.tiles - 1) / 2);
    chk({tag, " clear_cycles"}, clr_seen, v.exp_clr);
    chk({tag, " done_pulses"}, done_cnt, 1);
    chk({tag, " pixel_data"}, pix_err, 0);
    chk({tag, " pixel_hold"}, hold_err, 0);
    chk({tag, " load_end_align"}, le_err, 0);
    chk({tag, " err_unexp"}, int'(err_unexp), v.exp_unexp);
    chk({tag, " err_timeout"}, int'(err_timeout), 0);
    chk({tag, " busy_after"}, int'(busy), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tab[4];
    bit ok;
    int cnt;
    tab[0] = '{tiles: 1, src_gap: 0, rd_gap: 0, inj: -1, exp_en: 80,  exp_edges: 324, exp_clr: 1, exp_unexp: 0};
    tab[1] = '{tiles: 2, src_gap: 1, rd_gap: 0, inj: -1, exp_en: 160, exp_edges: 648, exp_clr: 2, exp_unexp: 0};
    tab[2] = '{tiles: 3, src_gap: 0, rd_gap: 1, inj: -1, exp_en: 240, exp_edges: 972, exp_clr: 3, exp_unexp: 0};
    tab[3] = '{tiles: 1, src_gap: 0, rd_gap: 0, inj: 10, exp_en: 80,  exp_edges: 324, exp_clr: 1, exp_unexp: 1};

    reset = 1'b1; start = 1'b0; num_tiles = '0; src_valid = 1'b0; src_data = '0;
    core_readable = 1'b0; core_edge = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst busy", int'(busy), 0);
    chk("rst src_ready", int'(src_ready), 0);
    chk("rst core_pixel", int'(core_pixel), 0);
    chk("rst core_clear", int'(core_clear), 0);
    chk("rst core_load_end", int'(core_load_end), 0);
    chk("rst tile_idx", int'(tile_idx), 0);
    chk("rst errors", int'({err_unexp, err_timeout}), 0);
    chk("rst done", int'(done), 0);
    reset = 1'b0;

    // zero tiles: done two cycles after the accepting edge, no clear
    clear_mon();
    kick(8'd0);
    chk("zero n1 done", int'(done), 0);
    chk("zero n1 busy", int'(busy), 1);
    @(negedge clk);
    chk("zero n2 done", int'(done), 1);
    @(negedge clk);
    chk("zero n3 done", int'(done), 0);
    chk("zero n3 busy", int'(busy), 0);
    chk("zero clear_cycles", clr_seen, 0);

    // drain timeout, also checks start-to-ready timing
    clear_mon();
    kick(8'd1);
    chk("to clear_n1", int'(core_clear), 1);
    chk("to ready_n1", int'(src_ready), 0);
    @(negedge clk);
    chk("to clear_n2", int'(core_clear), 0);
    chk("to ready_n2", int'(src_ready), 1);
    src_tile(0, 1'b0, -1, ok);
    chk("to load_ok", int'(ok), 1);
    chk("to load_end", int'(core_load_end), 1);
    cnt = 0;
    while (!done && cnt < 3000) begin @(negedge clk); cnt++; end
    chk("to done_delay", cnt, 1025);
    chk("to err_timeout", int'(err_timeout), 1);
    chk("to load_end_low", int'(core_load_end), 0);
    chk("to edges", ev_cnt, 0);
    chk("to core_en_count", en_cnt, 80);
    repeat (3) @(negedge clk);

    for (int i = 0; i < 4; i++) run_vec($sformatf("vec%0d", i), tab[i]);

    // reset during DRAIN after 100 edge bits
    clear_mon();
    kick(8'd1);
    src_tile(0, 1'b0, -1, ok);
    core_bits(0, 100, 1'b0, ok);
    chk("rd drain_ok", int'(ok), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("rd busy", int'(busy), 0);
    chk("rd load_end", int'(core_load_end), 0);
    chk("rd edge_valid", int'(edge_valid), 0);
    chk("rd core_pixel", int'(core_pixel), 0);
    chk("rd tile_idx", int'(tile_idx), 0);
    chk("rd edges_before", ev_cnt, 100);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("rd no_done", done_cnt, 0);
    run_vec("after_rst", tab[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
